rv32_control_unit: RTL and testbench
====================================

# rv32_control_unit

Main decoder of the single-cycle RV32I core. It takes the opcode, funct3 and funct7 fields of the current instruction and drives the datapath control strobes and the 4-bit ALU operation. These outputs are combinational, so they are valid in the same cycle as the instruction. A small clocked block records illegal instructions for debug.

## Interface
- `CNT_W`, default 8: width of the saturating illegal-instruction counter.

- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `valid`  in  1: instruction fields are meaningful; 0 means bubble.
- `opcode`  in  7: instruction bits [6:0].
- `funct3`  in  3: instruction bits [14:12].
- `funct7`  in  7: instruction bits [31:25].
- `RegWrite`  out  1: write the destination register.
- `MemRead`  out  1: data-memory read.
- `MemWrite`  out  1: data-memory write.
- `MemToReg`  out  1: writeback source is memory (1) or ALU (0).
- `Branch`  out  1: conditional branch.
- `ALUSrc`  out  1: ALU operand B is the immediate (1) or rs2 (0).
- `ALUctl`  out  4: ALU operation.
- `Illegal`  out  1: current instruction is illegal (combinational).
- `illegal_seen`  out  1: sticky illegal flag (registered).
- `illegal_count`  out  CNT_W: saturating count of illegal instructions (registered).

## Operation
- ALUctl encoding:
  - AND=0000, OR=0001, ADD=0010, XOR=0011.
  - SLL=0100, SRL=0101, SUB=0110, SLT=0111.
  - SRA=1000, SLTU=1001.
- Default for every strobe is 0; default ALUctl is ADD.
- R-type, opcode 0110011: RegWrite=1, ALUSrc=0.
  - funct3 000: ADD, or SUB if funct7[5]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - funct3 101: SRL, or SRA if funct7[5]=1.
- I-ALU, opcode 0010011: RegWrite=1, ALUSrc=1.
  - Same funct3 map as R-type, except funct3 000 is always ADD (funct7 ignored).
  - funct3 101 selects SRA when funct7[5]=1.
- LOAD, opcode 0000011: RegWrite=1, MemRead=1, MemToReg=1, ALUSrc=1, ADD.
- STORE, opcode 0100011: MemWrite=1, ALUSrc=1, ADD.
- BRANCH, opcode 1100011: Branch=1, ALUSrc=0.
  - funct3 000/001: SUB. 100/101: SLT. 110/111: SLTU.
  - funct3 010/011 is illegal.
- Any other opcode is illegal.
- When an instruction is illegal, or valid=0: all strobes are 0 and ALUctl=ADD.
- Illegal is asserted only when valid=1 and the decode is illegal.

## Timing
- All decode outputs, including Illegal, are purely combinational from the inputs, with zero latency.
- rst does not gate the decode outputs.
- On each rising clk edge:
  - If rst=1: illegal_seen←0 and illegal_count←0. Reset has priority over everything else.
  - Else if Illegal=1: illegal_seen←1, and illegal_count increments, saturating at all-ones.
  - Otherwise the registers hold.
- Reset values: illegal_seen=0, illegal_count=0.
- If reset is asserted in the same cycle as an illegal instruction, the registers clear and the illegal event is dropped.

## Configuration
- Macro `CTRL_STRICT_DECODE_EN`, when defined, adds these illegal checks:
  - R-type: funct7 must be 0000000, or 0100000 for funct3 000/101 only.
  - I-ALU shifts: funct7 must be 0000000 for SLLI; 0000000 or 0100000 for SRLI/SRAI.
  - LOAD: funct3 must be one of 000/001/010/100/101.
  - STORE: funct3 must be one of 000/001/010.
- When the macro is undefined, only funct7[5] is consulted and any load/store funct3 decodes as legal.
- Opcode legality and branch funct3 checks apply in both builds.

## Structure
- Shared package `ctrl_pkg`:
  - ALUctl localparams (ALU_AND…ALU_SLTU).
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH).
- One natural sub-module, `alu_decoder`: maps opcode class, funct3 and funct7 to ALUctl plus an ALU-level illegal flag.
- The top level holds the main decode and the sticky/counter registers.

## Test plan
- R ADD then SUB:
  - opcode 0110011, funct3 000, funct7 0000000 -> RegWrite=1, ALUSrc=0, ALUctl=0010.
  - Same with funct7 0100000 -> ALUctl=0110.
- LOAD lw, opcode 0000011, funct3 010 -> RegWrite=1, MemRead=1, MemToReg=1, ALUSrc=1, ALUctl=0010.
- STORE sw, funct3 010 -> MemWrite=1, ALUSrc=1, ALUctl=0010, RegWrite=0.
- BEQ, opcode 1100011, funct3 000 -> Branch=1, ALUSrc=0, ALUctl=0110.
- ADDI, opcode 0010011, funct3 000, funct7 0100000 -> RegWrite=1, ALUSrc=1, ALUctl=0010.
- Illegal and registers:
  - Opcode 1111111 with valid=1 -> Illegal=1 and all strobes 0.
  - After the next edge, illegal_seen=1 and illegal_count=1.
  - Holding it 300 cycles saturates illegal_count at 255.
  - Asserting rst clears both on the next edge.
  - With valid=0, Illegal=0 and the count does not change.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I control unit: ALU operation codes, major
// opcodes and the opcode-class enum used between the main and ALU decoders.
package ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_IMM:    return CLS_IMM;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps opcode class plus funct3/funct7 to the ALU operation and an illegal flag.
// Define CTRL_STRICT_DECODE_EN to also reject non-canonical funct7 and load/store funct3.
module alu_decoder
  import ctrl_pkg::*;
(
  input  op_class_e   op_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [3:0]  alu_ctl,
  output logic        alu_illegal
);

`ifdef CTRL_STRICT_DECODE_EN
  logic f7_zero, f7_alt;
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
`else
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
`endif

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alu_ctl     = ALU_ADD;
    alu_illegal = 1'b0;
    case (op_class)
      CLS_R, CLS_IMM: begin
        case (funct3)
          3'b000:  alu_ctl = (op_class == CLS_R && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctl = ALU_SLL;
          3'b010:  alu_ctl = ALU_SLT;
          3'b011:  alu_ctl = ALU_SLTU;
          3'b100:  alu_ctl = ALU_XOR;
          3'b101:  alu_ctl = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctl = ALU_OR;
          default: alu_ctl = ALU_AND;
        endcase
`ifdef CTRL_STRICT_DECODE_EN
        if (op_class == CLS_R)
          alu_illegal = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
        else if (funct3 == 3'b001)
          alu_illegal = !f7_zero;
        else if (funct3 == 3'b101)
          alu_illegal = !(f7_zero || f7_alt);
`endif
      end
      CLS_LOAD: begin
`ifdef CTRL_STRICT_DECODE_EN
        alu_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
`endif
      end
      CLS_STORE: begin
`ifdef CTRL_STRICT_DECODE_EN
        alu_illegal = (funct3[2] || funct3 == 3'b011);
`endif
      end
      CLS_BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_ctl = ALU_SUB;
          2'b10:   alu_ctl = ALU_SLT;
          2'b11:   alu_ctl = ALU_SLTU;
          default: alu_illegal = 1'b1;
        endcase
      end
      default: alu_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_control_unit.sv
// Single-cycle RV32I main decoder with registered sticky/saturating illegal tracking.
// Optional CTRL_STRICT_DECODE_EN tightens funct field checks in alu_decoder.
module rv32_control_unit
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             Branch,
  output logic             ALUSrc,
  output logic [3:0]       ALUctl,
  output logic             Illegal,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] illegal_count
);

  op_class_e        op_class;
  logic [3:0]       alu_ctl;
  logic             alu_illegal;
  logic             illegal_seen_d, illegal_seen_q;
  logic [CNT_W-1:0] illegal_count_d, illegal_count_q;

  assign op_class = classify(opcode);

  alu_decoder u_alu_decoder (
    .op_class    (op_class),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_ctl     (alu_ctl),
    .alu_illegal (alu_illegal)
  );

  always_comb begin
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    Branch   = 1'b0;
    ALUSrc   = 1'b0;
    ALUctl   = ALU_ADD;
    Illegal  = valid && alu_illegal;
    // Bubbles and illegal instructions must not disturb architectural state.
    if (valid && !alu_illegal) begin
      ALUctl = alu_ctl;
      case (op_class)
        CLS_R:      RegWrite = 1'b1;
        CLS_IMM:    begin RegWrite = 1'b1; ALUSrc = 1'b1; end
        CLS_LOAD:   begin RegWrite = 1'b1; MemRead = 1'b1; MemToReg = 1'b1; ALUSrc = 1'b1; end
        CLS_STORE:  begin MemWrite = 1'b1; ALUSrc = 1'b1; end
        CLS_BRANCH: Branch = 1'b1;
        default:    ;
      endcase
    end
  end

  always_comb begin
    illegal_seen_d  = illegal_seen_q | Illegal;
    illegal_count_d = illegal_count_q;
    if (Illegal && illegal_count_q != '1)
      illegal_count_d = illegal_count_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen_q  <= 1'b0;
      illegal_count_q <= '0;
    end else begin
      illegal_seen_q  <= illegal_seen_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign illegal_seen  = illegal_seen_q;
  assign illegal_count = illegal_count_q;

endmodule

// File: tb/tb_rv32_control_unit.sv
// Scoreboard bench for rv32_control_unit: driver queues expected decode and
// register state per vector, a negedge monitor pops and compares.
module tb_rv32_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, Illegal;
  logic [3:0] ALUctl;
  logic       illegal_seen;
  logic [7:0] illegal_count;

  always #5 clk = ~clk;

  rv32_control_unit #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid         (valid),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .RegWrite      (RegWrite),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemToReg      (MemToReg),
    .Branch        (Branch),
    .ALUSrc        (ALUSrc),
    .ALUctl        (ALUctl),
    .Illegal       (Illegal),
    .illegal_seen  (illegal_seen),
    .illegal_count (illegal_count)
  );

  typedef struct {
    string      name;
    logic [6:0] strobes;  // {RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, Illegal}
    logic [3:0] alu;
    logic       seen;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       m_seen   = 1'b0;
  logic [7:0] m_cnt    = '0;
  logic       prev_rst = 1'b1;
  logic       prev_ill = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one vector for a full cycle; register expectations reflect all prior edges.
  task automatic vec(input string name, input logic r, input logic v, input logic [6:0] op,
                     input logic [2:0] f3, input logic [6:0] f7,
                     input logic [6:0] strb, input logic [3:0] alu);
    @(posedge clk);
    if (prev_rst) begin
      m_seen = 1'b0;
      m_cnt  = 8'd0;
    end else if (prev_ill) begin
      m_seen = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    #1;
    rst = r; valid = v; opcode = op; funct3 = f3; funct7 = f7;
    sb_q.push_back('{name, strb, alu, m_seen, m_cnt});
    prev_rst = r;
    prev_ill = strb[0];
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.name, "/decode"},
            {5'd0, RegWrite, MemRead, MemWrite, MemToReg, Branch, ALUSrc, Illegal, ALUctl},
            {5'd0, e.strobes, e.alu});
      check({e.name, "/regs"}, {7'd0, illegal_seen, illegal_count}, {7'd0, e.seen, e.cnt});
    end
  end

  initial begin
    vec("r_add_rst", 1, 1, 7'b0110011, 3'b000, 7'b0000000, 7'b1000000, 4'b0010);
    vec("r_add",     0, 1, 7'b0110011, 3'b000, 7'b0000000, 7'b1000000, 4'b0010);
    vec("r_sub",     0, 1, 7'b0110011, 3'b000, 7'b0100000, 7'b1000000, 4'b0110);
    vec("r_sra",     0, 1, 7'b0110011, 3'b101, 7'b0100000, 7'b1000000, 4'b1000);
    vec("r_srl",     0, 1, 7'b0110011, 3'b101, 7'b0000000, 7'b1000000, 4'b0101);
    vec("r_sltu",    0, 1, 7'b0110011, 3'b011, 7'b0000000, 7'b1000000, 4'b1001);
    vec("r_and",     0, 1, 7'b0110011, 3'b111, 7'b0000000, 7'b1000000, 4'b0000);
    vec("lw",        0, 1, 7'b0000011, 3'b010, 7'b0000000, 7'b1101010, 4'b0010);
    vec("sw",        0, 1, 7'b0100011, 3'b010, 7'b0000000, 7'b0010010, 4'b0010);
    vec("beq",       0, 1, 7'b1100011, 3'b000, 7'b0000000, 7'b0000100, 4'b0110);
    vec("blt",       0, 1, 7'b1100011, 3'b100, 7'b0000000, 7'b0000100, 4'b0111);
    vec("bgeu",      0, 1, 7'b1100011, 3'b111, 7'b0000000, 7'b0000100, 4'b1001);
    vec("addi_f7",   0, 1, 7'b0010011, 3'b000, 7'b0100000, 7'b1000010, 4'b0010);
    vec("slli",      0, 1, 7'b0010011, 3'b001, 7'b0000000, 7'b1000010, 4'b0100);
    vec("srai",      0, 1, 7'b0010011, 3'b101, 7'b0100000, 7'b1000010, 4'b1000);
    vec("ori",       0, 1, 7'b0010011, 3'b110, 7'b0000000, 7'b1000010, 4'b0001);
`ifdef CTRL_STRICT_DECODE_EN
    vec("r_odd_f7",  0, 1, 7'b0110011, 3'b000, 7'b0000001, 7'b0000001, 4'b0010);
    vec("load_f3_3", 0, 1, 7'b0000011, 3'b011, 7'b0000000, 7'b0000001, 4'b0010);
`else
    vec("r_odd_f7",  0, 1, 7'b0110011, 3'b000, 7'b0000001, 7'b1000000, 4'b0010);
    vec("load_f3_3", 0, 1, 7'b0000011, 3'b011, 7'b0000000, 7'b1101010, 4'b0010);
`endif
    vec("bubble_r",  0, 0, 7'b0110011, 3'b000, 7'b0000000, 7'b0000000, 4'b0010);
    vec("br_f3_010", 0, 1, 7'b1100011, 3'b010, 7'b0000000, 7'b0000001, 4'b0010);
    vec("bad_op",    0, 1, 7'b1111111, 3'b000, 7'b0000000, 7'b0000001, 4'b0010);
    vec("bubble_bad",0, 0, 7'b1111111, 3'b000, 7'b0000000, 7'b0000000, 4'b0010);
    vec("after_bub", 0, 0, 7'b0000000, 3'b000, 7'b0000000, 7'b0000000, 4'b0010);
    for (int i = 0; i < 300; i++)
      vec("hold_ill", 0, 1, 7'b1111111, 3'b000, 7'b0000000, 7'b0000001, 4'b0010);
    vec("sat_hold",  0, 0, 7'b0000000, 3'b000, 7'b0000000, 7'b0000000, 4'b0010);
    vec("rst_ill",   1, 1, 7'b1111111, 3'b000, 7'b0000000, 7'b0000001, 4'b0010);
    vec("post_rst",  0, 0, 7'b0000000, 3'b000, 7'b0000000, 7'b0000000, 4'b0010);
    vec("ill_again", 0, 1, 7'b0001111, 3'b000, 7'b0000000, 7'b0000001, 4'b0010);
    vec("count_one", 0, 0, 7'b0110011, 3'b000, 7'b0000000, 7'b0000000, 4'b0010);
    vec("count_hold",0, 1, 7'b0110011, 3'b100, 7'b0000000, 7'b1000000, 4'b0011);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
